// File: rtl/baud_sel_gen.sv
// Programmable baud-tick generator: divides clk into a one-cycle 'baud' strobe at
// OVERSAMPLE x the rate chosen by baud_sel. The strobe is registered.
module baud_sel_gen #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 16
) (
  input  logic [1:0] baud_sel,
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_baud,
  output logic       baud
);

  function automatic int rate_of(input int idx);
    case (idx)
      0:       return 9600;
      1:       return 19200;
      2:       return 38400;
      default: return 57600;
    endcase
  endfunction

  // Truncating divide; anything under 2 would leave no room between ticks.
  function automatic int div_of(input int rate);
    int d;
    d = CLK_FREQ / (rate * OVERSAMPLE);
    return (d < 2) ? 2 : d;
  endfunction

  logic [CNT_W-1:0] last_tbl [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_div
      localparam int DIV = div_of(rate_of(gi));
      assign last_tbl[gi] = CNT_W'(DIV - 1);
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             baud_q, baud_d;
  logic [1:0]       sel_q;
  logic             rate_chg;

  assign rate_chg = (baud_sel != sel_q);

  // Priority: disable, then rate change, then the normal wrap/increment.
  always_comb begin
    cnt_d  = cnt_q;
    baud_d = 1'b0;
    if (!enable_baud) begin
      cnt_d = '0;
    end else if (rate_chg) begin
      cnt_d = '0;
    end else if (cnt_q == last_tbl[sel_q]) begin
      cnt_d  = '0;
      baud_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      baud_q <= 1'b0;
      sel_q  <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      baud_q <= baud_d;
      sel_q  <= baud_sel;
    end
  end

  assign baud = baud_q;

endmodule

// File: tb/tb_baud_sel_gen.sv
// Directed bench for baud_sel_gen: a per-rate vector table plus hand-written
// sequences for rate switching, wrap collisions, enable drop and reset.
`timescale 1ns/100ps
module tb_baud_sel_gen;

  logic [1:0] baud_sel;
  logic       clk;
  logic       rst;
  logic       enable_baud;
  logic       baud;

  int n_cmp = 0;
  int n_bad = 0;

  baud_sel_gen dut (
    .baud_sel    (baud_sel),
    .clk         (clk),
    .rst         (rst),
    .enable_baud (enable_baud),
    .baud        (baud)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    int         div;
    int         periods;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #0.5;
  endtask

  // Returns the number of edges until baud is seen high, or 0 on timeout.
  task automatic count_to_tick(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick_edge();
      if (baud === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic wait_edges(input int k);
    for (int i = 0; i < k; i++) tick_edge();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int   n;
    int   hits;

    vecs[0] = '{2'b00, 325, 3};
    vecs[1] = '{2'b01, 162, 3};
    vecs[2] = '{2'b10,  81, 4};
    vecs[3] = '{2'b11,  54, 4};

    rst         = 1'b0;
    enable_baud = 1'b0;
    baud_sel    = 2'b00;

    // Reset held 10 ns, then released with the generator idle.
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick_edge();
      if (baud !== 1'b0) hits++;
    end
    check("reset_baud_low", hits, 0);
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick_edge();
      if (baud !== 1'b0) hits++;
    end
    check("idle_after_reset", hits, 0);
    $display("seq reset: idle checks done");

    foreach (vecs[v]) begin
      enable_baud = 1'b0;
      baud_sel    = vecs[v].sel;
      wait_edges(2);
      check($sformatf("vec%0d_idle", v), int'(baud), 0);
      enable_baud = 1'b1;
      count_to_tick(1000, n);
      check($sformatf("vec%0d_first", v), n, vecs[v].div);
      for (int p = 0; p < vecs[v].periods; p++) begin
        count_to_tick(1000, n);
        check($sformatf("vec%0d_period%0d", v, p), n, vecs[v].div);
      end
      $display("vec %0d sel=%b div=%0d last_period=%0d", v, vecs[v].sel, vecs[v].div, n);
    end

    // Rate change mid-count: 00 -> 01.
    enable_baud = 1'b0;
    baud_sel    = 2'b00;
    wait_edges(2);
    enable_baud = 1'b1;
    count_to_tick(1000, n);
    check("sw_first00", n, 325);
    wait_edges(100);
    baud_sel = 2'b01;
    tick_edge();
    check("sw_cycle_no_tick", int'(baud), 0);
    count_to_tick(1000, n);
    check("sw_first01", n, 162);
    count_to_tick(1000, n);
    check("sw_period01", n, 162);
    $display("seq switch 00->01: first=162 path checked, period=%0d", n);

    // Rate change landing exactly on the wrap edge must suppress the tick.
    enable_baud = 1'b0;
    baud_sel    = 2'b11;
    wait_edges(2);
    enable_baud = 1'b1;
    count_to_tick(1000, n);
    check("wrap_first11", n, 54);
    wait_edges(53);
    check("wrap_pre_no_tick", int'(baud), 0);
    baud_sel = 2'b10;
    tick_edge();
    check("wrap_vs_switch", int'(baud), 0);
    count_to_tick(1000, n);
    check("wrap_first10", n, 81);
    $display("seq wrap collision 11->10: next tick after %0d", n);

    // Drop enable mid-count, then re-enable for a full period.
    wait_edges(40);
    enable_baud = 1'b0;
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      tick_edge();
      if (baud !== 1'b0) hits++;
    end
    check("disabled_no_tick", hits, 0);
    enable_baud = 1'b1;
    count_to_tick(1000, n);
    check("reenable_first", n, 81);
    $display("seq enable drop: reenable tick after %0d", n);

    // Async reset while baud is high: must drop before the next edge.
    check("rst_pre_baud_high", int'(baud), 1);
    baud_sel = 2'b00;
    rst = 1'b0;
    #0.2;
    check("async_rst_drop", int'(baud), 0);
    wait_edges(3);
    check("rst_held_low", int'(baud), 0);
    rst = 1'b1;
    count_to_tick(1000, n);
    check("rst_release_first", n, 325);
    $display("seq reset mid-run: tick after %0d", n);

    // Reset while a non-default rate is selected: sel_q comes out as 00,
    // so the first edge is a rate change and the tick is one edge later.
    baud_sel = 2'b01;
    rst = 1'b0;
    wait_edges(2);
    rst = 1'b1;
    count_to_tick(1000, n);
    check("rst_sel01_first", n, 163);
    count_to_tick(1000, n);
    check("rst_sel01_period", n, 162);
    $display("seq reset with sel=01: period=%0d", n);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
